// File: rtl/vend_sequencer.sv
// Sequenced vending controller: coin credit, price-checked vend, dispenser handshake, 5-unit change train.
// Optional VEND_CANCEL_EN adds a cancel input that refunds the whole credit from COLLECT.
module vend_sequencer #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 35,
    parameter int CREDIT_W    = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          coin,
    input  logic                sel,
    input  logic                disp_ack,
`ifdef VEND_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                disp_req,
    output logic                change_pulse,
    output logic                reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE_C   = CREDIT_W'(5);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t             state;
    logic [TMO_W-1:0]   tmo;
    logic               cancel_req;
    logic               accepting;
    logic               coin_ok;
    logic [CREDIT_W:0]  coin_val;
    logic [CREDIT_W:0]  coin_sum;
    logic [CREDIT_W-1:0] add_credit;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = (CREDIT_W + 1)'(5);
            2'b10:   coin_val = (CREDIT_W + 1)'(10);
            default: coin_val = '0;
        endcase
        accepting  = (state == IDLE) || (state == COLLECT);
        coin_sum   = {1'b0, credit} + coin_val;
        coin_ok    = accepting && (coin == 2'b01 || coin == 2'b10) && (coin_sum <= MAX_C);
        add_credit = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            credit       <= '0;
            disp_req     <= 1'b0;
            change_pulse <= 1'b0;
            reject       <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            tmo          <= '0;
        end else begin
            reject       <= (coin != 2'b00) && !coin_ok;
            change_pulse <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (state == COLLECT && cancel_req) begin
                        // Refund includes any coin accepted this cycle; first pulse goes out immediately.
                        state        <= CHANGE;
                        credit       <= add_credit - FIVE_C;
                        change_pulse <= 1'b1;
                        busy         <= 1'b1;
                    end else if (state == COLLECT && sel && credit >= PRICE_C) begin
                        state    <= DISPENSE;
                        credit   <= add_credit - PRICE_C;
                        disp_req <= 1'b1;
                        busy     <= 1'b1;
                        tmo      <= '0;
                    end else begin
                        credit <= add_credit;
                        state  <= (add_credit == '0) ? IDLE : COLLECT;
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        tmo      <= '0;
                        if (credit != '0) begin
                            state        <= CHANGE;
                            credit       <= credit - FIVE_C;
                            change_pulse <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tmo == TMO_LAST) begin
                        disp_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                CHANGE: begin
                    // Credit drops together with each pulse, so a high pulse with zero credit ends the train.
                    if (change_pulse) begin
                        if (credit == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        credit       <= credit - FIVE_C;
                        change_pulse <= 1'b1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer; cancel scenarios run only when VEND_CANCEL_EN is defined.
module tb_vend_sequencer;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel = 1'b0;
    logic       disp_ack = 1'b0;
`ifdef VEND_CANCEL_EN
    logic       cancel = 1'b0;
`endif
    logic       disp_req, change_pulse, reject, busy, fault;
    logic [5:0] credit;

    int checks = 0;
    int failures = 0;
    int pulses;
    int cyc;

    vend_sequencer dut (
        .clk(clk), .rstn(rstn), .coin(coin), .sel(sel), .disp_ack(disp_ack),
`ifdef VEND_CANCEL_EN
        .cancel(cancel),
`endif
        .disp_req(disp_req), .change_pulse(change_pulse), .reject(reject),
        .credit(credit), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int c, input int dr, input int cp,
                        input int rj, input int bz, input int ft);
        chk({tag, ".credit"}, int'(credit), c);
        chk({tag, ".disp_req"}, int'(disp_req), dr);
        chk({tag, ".change_pulse"}, int'(change_pulse), cp);
        chk({tag, ".reject"}, int'(reject), rj);
        chk({tag, ".busy"}, int'(busy), bz);
        chk({tag, ".fault"}, int'(fault), ft);
        $display("step %-14s credit=%0d disp_req=%0b pulse=%0b reject=%0b busy=%0b fault=%0b",
                 tag, credit, disp_req, change_pulse, reject, busy, fault);
    endtask

    // Counts change pulses until busy drops; expired budget is a failed comparison.
    task automatic drain(input string tag, input int exp_pulses);
        pulses = int'(change_pulse);
        for (cyc = 0; cyc < 30 && busy; cyc++) begin
            tick();
            if (change_pulse) pulses++;
            chk({tag, ".no_disp_req"}, int'(disp_req), 0);
        end
        chk({tag, ".pulses"}, pulses, exp_pulses);
        chk({tag, ".done_busy"}, int'(busy), 0);
        chk({tag, ".done_credit"}, int'(credit), 0);
        $display("step %-14s pulses=%0d", tag, pulses);
    endtask

    initial begin
        #2;
        outs("reset", 0, 0, 0, 0, 0, 0);
        tick();
        rstn = 1'b1;

        // Simple exact-price vend, no change.
        coin = 2'b01; tick(); outs("c5", 5, 0, 0, 0, 0, 0);
        tick(); outs("c10", 10, 0, 0, 0, 0, 0);
        tick(); outs("c15", 15, 0, 0, 0, 0, 0);
        coin = 2'b00; sel = 1'b1; tick(); outs("vend", 0, 1, 0, 0, 1, 0);
        sel = 1'b0; tick(); outs("wait1", 0, 1, 0, 0, 1, 0);
        tick(); outs("wait2", 0, 1, 0, 0, 1, 0);
        disp_ack = 1'b1; tick(); outs("ack", 0, 0, 0, 0, 0, 0);
        disp_ack = 1'b0; tick(); outs("idle", 0, 0, 0, 0, 0, 0);

        // Credit 30 vend with three change pulses every other cycle.
        coin = 2'b10; tick(); tick(); tick(); outs("c30", 30, 0, 0, 0, 0, 0);
        coin = 2'b00; sel = 1'b1; tick(); outs("vend30", 15, 1, 0, 0, 1, 0);
        sel = 1'b0; disp_ack = 1'b1; tick(); outs("chg_p1", 10, 0, 1, 0, 1, 0);
        disp_ack = 1'b0; tick(); outs("chg_gap1", 10, 0, 0, 0, 1, 0);
        tick(); outs("chg_p2", 5, 0, 1, 0, 1, 0);
        tick(); outs("chg_gap2", 5, 0, 0, 0, 1, 0);
        tick(); outs("chg_p3", 0, 0, 1, 0, 1, 0);
        tick(); outs("chg_end", 0, 0, 0, 0, 0, 0);

        // Invalid coin in IDLE, overflow coin, boundary coin to exactly MAX_CREDIT.
        coin = 2'b11; tick(); outs("inv_idle", 0, 0, 0, 1, 0, 0);
        coin = 2'b10; tick(); outs("rj_clear", 10, 0, 0, 0, 0, 0);
        tick(); tick(); outs("c30b", 30, 0, 0, 0, 0, 0);
        tick(); outs("overflow", 30, 0, 0, 1, 0, 0);
        coin = 2'b01; tick(); outs("c35", 35, 0, 0, 0, 0, 0);
        coin = 2'b01; tick(); outs("ovf35", 35, 0, 0, 1, 0, 0);
        coin = 2'b00; sel = 1'b1; tick(); outs("vend35", 20, 1, 0, 0, 1, 0);
        sel = 1'b0; disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        outs("chg35", 15, 0, 1, 0, 1, 0);
        drain("drain35", 4);

        // Same-cycle coin does not enable the vend; next-cycle sel does.
        coin = 2'b10; tick(); outs("c10b", 10, 0, 0, 0, 0, 0);
        coin = 2'b01; sel = 1'b1; tick(); outs("sel_low", 15, 0, 0, 0, 0, 0);
        coin = 2'b00; tick(); outs("sel_ok", 0, 1, 0, 0, 1, 0);
        sel = 1'b0; coin = 2'b01; tick(); outs("coin_disp", 0, 1, 0, 1, 1, 0);
        coin = 2'b00; disp_ack = 1'b1; tick(); outs("ack_b", 0, 0, 0, 0, 0, 0);
        disp_ack = 1'b0; sel = 1'b1; tick(); outs("sel_idle", 0, 0, 0, 0, 0, 0);
        sel = 1'b0;

        // Reset asserted mid-CHANGE aborts at once.
        coin = 2'b10; tick(); tick(); tick();
        coin = 2'b00; sel = 1'b1; tick();
        sel = 1'b0; disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        outs("pre_rst", 10, 0, 1, 0, 1, 0);
        rstn = 1'b0; #1; outs("mid_rst", 0, 0, 0, 0, 0, 0);
        #1 rstn = 1'b1;
        tick(); outs("post_rst", 0, 0, 0, 0, 0, 0);

`ifdef VEND_CANCEL_EN
        // Cancel beats sel; whole credit refunded, no dispense.
        coin = 2'b10; tick(); tick();
        coin = 2'b01; tick(); outs("c25", 25, 0, 0, 0, 0, 0);
        coin = 2'b00; cancel = 1'b1; sel = 1'b1; tick(); outs("cancel", 20, 0, 1, 0, 1, 0);
        cancel = 1'b0; sel = 1'b0;
        drain("drain_cancel", 5);
        coin = 2'b10; tick();
        coin = 2'b01; cancel = 1'b1; tick(); outs("cancel_coin", 10, 0, 1, 0, 1, 0);
        coin = 2'b00; cancel = 1'b0;
        drain("drain_cc", 3);
`endif

        // Dispenser timeout leads to sticky FAULT.
        coin = 2'b01; tick(); tick(); tick();
        coin = 2'b00; sel = 1'b1; tick(); outs("vend_to", 0, 1, 0, 0, 1, 0);
        sel = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to_hold", int'(disp_req), 1);
        end
        tick(); outs("timeout", 0, 0, 0, 0, 1, 1);
        coin = 2'b10; disp_ack = 1'b1; sel = 1'b1; tick(); outs("fault_coin", 0, 0, 0, 1, 1, 1);
        coin = 2'b00; disp_ack = 1'b0; sel = 1'b0; tick(); outs("fault_hold", 0, 0, 0, 0, 1, 1);
        rstn = 1'b0; #1; outs("fault_rst", 0, 0, 0, 0, 0, 0);
        #1 rstn = 1'b1;
        tick(); outs("final", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
